hazard_ctrl: RTL and testbench

Pipeline hazard controller that sits directly upstream of the decode→execute control register. It takes the decoded control bundle and register addresses of the instruction in decode and gates it into a bubble when needed before handing it on. It tracks the destination registers of the instructions in execute and writeback, and generates stall, flush and operand-forwarding selects for the decode stage.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hz_match.sv | 12 +
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_EX = 2'd1,
      FWD_WB = 2'd2
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_t;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   // Destination-tracking entry for one downstream stage.
   typedef struct packed {
      logic       v;
      logic [4:0] waddr;
      logic       reg_wr;
      logic       rd;
   } shadow_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage bundle into the hazard controller and its gated/hazard outputs.
interface hazard_ctrl_if;
   import pipe_pkg::*;

   logic [4:0] raddr1;
   logic [4:0] raddr2;
   logic [4:0] waddr;
   logic       reg_wr_in;
   logic       rd_in;
   logic       cs_in;
   logic [1:0] wb_sel_in;
   logic       br_taken_in;
   logic       br_taken_e;

   logic       reg_wr;
   logic       rd;
   logic       cs;
   logic [1:0] wb_sel;
   logic       br_taken;
   logic       stall;
   logic       flush;
   fwd_sel_t   fwd_a;
   fwd_sel_t   fwd_b;

   modport master (
      output raddr1, raddr2, waddr, reg_wr_in, rd_in, cs_in, wb_sel_in, br_taken_in, br_taken_e,
      input  reg_wr, rd, cs, wb_sel, br_taken, stall, flush, fwd_a, fwd_b
   );

   modport slave (
      input  raddr1, raddr2, waddr, reg_wr_in, rd_in, cs_in, wb_sel_in, br_taken_in, br_taken_e,
      output reg_wr, rd, cs, wb_sel, br_taken, stall, flush, fwd_a, fwd_b
   );

endinterface

// File: rtl/hz_match.sv
// Source-vs-shadow comparator; x0 never matches.
module hz_match
   import pipe_pkg::*;
(
   input  logic [4:0] addr,
   input  shadow_t    ent,
   output logic       hit
);

   assign hit = ent.v & ent.reg_wr & (ent.waddr == addr) & (addr != REG_X0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the decode stage.
// Define HAZARD_FWD_EN for forwarding; otherwise every RAW hazard stalls.
module hazard_ctrl
   import pipe_pkg::*;
(
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave bus
);

   shadow_t  e_q, w_q, e_d;
   logic     m1e, m2e, m1w, m2w;
   logic     stall_c, flush_c, bubble;
   fwd_sel_t fwd_a_c, fwd_b_c;

   hz_match u_m1e (.addr(bus.raddr1), .ent(e_q), .hit(m1e));
   hz_match u_m2e (.addr(bus.raddr2), .ent(e_q), .hit(m2e));
   hz_match u_m1w (.addr(bus.raddr1), .ent(w_q), .hit(m1w));
   hz_match u_m2w (.addr(bus.raddr2), .ent(w_q), .hit(m2w));

`ifdef HAZARD_FWD_EN
   hz_state_t state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Flush wins over a simultaneous load-use; the pending stall is dropped.
   always_comb begin
      state_d = RUN;
      stall_c = 1'b0;
      flush_c = 1'b0;
      if (bus.br_taken_e) begin
         flush_c = 1'b1;
      end else if ((state_q == RUN) && (m1e | m2e) && e_q.rd) begin
         stall_c = 1'b1;
         state_d = LU_STALL;
      end
   end

   always_comb begin
      fwd_a_c = FWD_RF;
      fwd_b_c = FWD_RF;
      if (m1e & ~e_q.rd) fwd_a_c = FWD_EX;
      else if (m1w)      fwd_a_c = FWD_WB;
      if (m2e & ~e_q.rd) fwd_b_c = FWD_EX;
      else if (m2w)      fwd_b_c = FWD_WB;
   end
`else
   always_comb begin
      stall_c = 1'b0;
      flush_c = 1'b0;
      if (bus.br_taken_e)                flush_c = 1'b1;
      else if (m1e | m2e | m1w | m2w)    stall_c = 1'b1;
   end

   assign fwd_a_c = FWD_RF;
   assign fwd_b_c = FWD_RF;
`endif

   assign bubble = stall_c | flush_c;

   always_comb begin
      e_d        = '0;
      e_d.v      = ~bubble;
      e_d.waddr  = bus.waddr;
      e_d.reg_wr = bus.reg_wr_in & ~bubble;
      e_d.rd     = bus.rd_in & ~bubble;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         w_q <= e_q;
      end
   end

   always_comb begin
      bus.reg_wr   = bus.reg_wr_in & ~bubble;
      bus.rd       = bus.rd_in & ~bubble;
      bus.cs       = bus.cs_in & ~bubble;
      bus.wb_sel   = bubble ? WB_ALU : bus.wb_sel_in;
      bus.br_taken = bus.br_taken_in & ~bubble;
      bus.stall    = stall_c;
      bus.flush    = flush_c;
      bus.fwd_a    = fwd_a_c;
      bus.fwd_b    = fwd_b_c;
      if (rst) begin
         bus.reg_wr   = 1'b0;
         bus.rd       = 1'b0;
         bus.cs       = 1'b0;
         bus.wb_sel   = WB_ALU;
         bus.br_taken = 1'b0;
         bus.stall    = 1'b0;
         bus.flush    = 1'b0;
         bus.fwd_a    = FWD_RF;
         bus.fwd_b    = FWD_RF;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random traffic against an issue-history model.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   hazard_ctrl_if bus ();

   hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       v;
      bit [4:0] waddr;
      bit       wr;
      bit       rd;
   } ent_t;

   ent_t hist[2];  // [0] = last issued (execute), [1] = the one before (writeback)
   bit   lu_prev;

   logic [4:0] in_r1, in_r2, in_wa;
   logic       in_wr, in_rd, in_cs, in_bt, in_bte;
   logic [1:0] in_wb;

   logic       exp_reg_wr, exp_rd, exp_cs, exp_bt, exp_stall, exp_flush, exp_bub;
   logic [1:0] exp_wb, exp_fa, exp_fb;
   logic       obs_reg_wr, obs_stall, obs_flush;
   logic [1:0] obs_fa, obs_fb;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit hits(input logic [4:0] x, input int k);
      return (x != 5'd0) && hist[k].v && hist[k].wr && (hist[k].waddr == x);
   endfunction

   task automatic model_reset();
      hist[0] = '{0, 5'd0, 0, 0};
      hist[1] = '{0, 5'd0, 0, 0};
      lu_prev = 0;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (v) model_reset();
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wa,
                        input logic wr, input logic rd, input logic cs, input logic [1:0] wb,
                        input logic bt, input logic bte);
      in_r1 = r1; in_r2 = r2; in_wa = wa; in_wr = wr; in_rd = rd; in_cs = cs;
      in_wb = wb; in_bt = bt; in_bte = bte;
      bus.raddr1 = r1; bus.raddr2 = r2; bus.waddr = wa; bus.reg_wr_in = wr; bus.rd_in = rd;
      bus.cs_in = cs; bus.wb_sel_in = wb; bus.br_taken_in = bt; bus.br_taken_e = bte;
   endtask

   task automatic predict();
      bit h1e, h2e, h1w, h2w;
      h1e = hits(in_r1, 0); h2e = hits(in_r2, 0);
      h1w = hits(in_r1, 1); h2w = hits(in_r2, 1);
      exp_flush = in_bte;
`ifdef HAZARD_FWD_EN
      exp_stall = !in_bte && !lu_prev && (h1e || h2e) && hist[0].rd;
      exp_fa = (h1e && !hist[0].rd) ? 2'd1 : (h1w ? 2'd2 : 2'd0);
      exp_fb = (h2e && !hist[0].rd) ? 2'd1 : (h2w ? 2'd2 : 2'd0);
`else
      exp_stall = !in_bte && (h1e || h2e || h1w || h2w);
      exp_fa = 2'd0;
      exp_fb = 2'd0;
`endif
      exp_bub    = exp_flush || exp_stall;
      exp_reg_wr = in_wr && !exp_bub;
      exp_rd     = in_rd && !exp_bub;
      exp_cs     = in_cs && !exp_bub;
      exp_bt     = in_bt && !exp_bub;
      exp_wb     = exp_bub ? 2'd0 : in_wb;
      if (rst) begin
         {exp_reg_wr, exp_rd, exp_cs, exp_bt, exp_stall, exp_flush} = '0;
         exp_wb = 2'd0; exp_fa = 2'd0; exp_fb = 2'd0;
      end
   endtask

   // One pipeline cycle: check at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      @(negedge clk);
      predict();
      obs_reg_wr = bus.reg_wr; obs_stall = bus.stall; obs_flush = bus.flush;
      obs_fa = bus.fwd_a; obs_fb = bus.fwd_b;
      chk("reg_wr", {1'b0, bus.reg_wr}, {1'b0, exp_reg_wr});
      chk("rd", {1'b0, bus.rd}, {1'b0, exp_rd});
      chk("cs", {1'b0, bus.cs}, {1'b0, exp_cs});
      chk("br_taken", {1'b0, bus.br_taken}, {1'b0, exp_bt});
      chk("wb_sel", bus.wb_sel, exp_wb);
      chk("stall", {1'b0, bus.stall}, {1'b0, exp_stall});
      chk("flush", {1'b0, bus.flush}, {1'b0, exp_flush});
      chk("fwd_a", bus.fwd_a, exp_fa);
      chk("fwd_b", bus.fwd_b, exp_fb);
      @(posedge clk);
      if (!rst) begin
         hist[1] = hist[0];
         hist[0] = '{!exp_bub, in_wa, exp_reg_wr, exp_rd};
         lu_prev = exp_stall;
      end
      #1;
   endtask

   initial begin
      model_reset();
      set_rst(1'b1);
      drive(5'd3, 5'd4, 5'd3, 1, 1, 1, 2'd2, 1, 1);
      cycle();
      chk("rst_reg_wr", {1'b0, obs_reg_wr}, 2'd0);
      drive(5'd7, 5'd7, 5'd9, 1, 0, 1, 2'd1, 1, 0);
      cycle();
      set_rst(1'b0);

      // Plain pass-through after reset.
      drive(5'd0, 5'd0, 5'd5, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
      chk("post_rst_reg_wr", {1'b0, obs_reg_wr}, 2'd1);
      chk("post_rst_stall", {1'b0, obs_stall}, 2'd0);

      // ALU RAW on x5.
      drive(5'd5, 5'd0, 5'd9, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
`ifdef HAZARD_FWD_EN
      chk("raw_fwd_a_ex", obs_fa, 2'd1);
      chk("raw_stall", {1'b0, obs_stall}, 2'd0);
      drive(5'd0, 5'd5, 5'd0, 0, 0, 0, WB_ALU, 0, 0);
      cycle();
      chk("raw_fwd_b_wb", obs_fb, 2'd2);
`endif

      // Load-use on x7.
      drive(5'd0, 5'd0, 5'd7, 1, 1, 1, WB_MEM, 0, 0);
      cycle();
      drive(5'd7, 5'd0, 5'd8, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
`ifdef HAZARD_FWD_EN
      chk("lu_stall", {1'b0, obs_stall}, 2'd1);
      chk("lu_bubble", {1'b0, obs_reg_wr}, 2'd0);
      cycle();
      chk("lu_release", {1'b0, obs_stall}, 2'd0);
      chk("lu_fwd_a_wb", obs_fa, 2'd2);
      chk("lu_pass", {1'b0, obs_reg_wr}, 2'd1);
`else
      cycle();
      cycle();
`endif

      // x0 never forwards or stalls.
      drive(5'd0, 5'd0, 5'd0, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
      drive(5'd0, 5'd0, 5'd6, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
      chk("x0_fwd_a", obs_fa, 2'd0);
      chk("x0_stall", {1'b0, obs_stall}, 2'd0);

      // Flush beats a simultaneous load-use.
      drive(5'd0, 5'd0, 5'd7, 1, 1, 1, WB_MEM, 0, 0);
      cycle();
      drive(5'd7, 5'd0, 5'd8, 1, 0, 1, WB_ALU, 1, 1);
      cycle();
      chk("flush_flush", {1'b0, obs_flush}, 2'd1);
      chk("flush_stall", {1'b0, obs_stall}, 2'd0);
      chk("flush_bubble", {1'b0, obs_reg_wr}, 2'd0);
      drive(5'd7, 5'd0, 5'd8, 1, 0, 1, WB_ALU, 0, 0);
      cycle();

      // Reset in the middle of a load-use stall.
      drive(5'd0, 5'd0, 5'd4, 1, 1, 1, WB_MEM, 0, 0);
      cycle();
      drive(5'd0, 5'd4, 5'd2, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
      set_rst(1'b1);
      cycle();
      set_rst(1'b0);
      cycle();
      chk("rst_abandon_stall", {1'b0, obs_stall}, 2'd0);

      // RAW on x3 without forwarding stalls twice.
      drive(5'd0, 5'd0, 5'd3, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
      drive(5'd0, 5'd3, 5'd1, 1, 0, 1, WB_ALU, 0, 0);
      cycle();
`ifndef HAZARD_FWD_EN
      chk("nofwd_stall1", {1'b0, obs_stall}, 2'd1);
      cycle();
      chk("nofwd_stall2", {1'b0, obs_stall}, 2'd1);
      cycle();
      chk("nofwd_release", {1'b0, obs_stall}, 2'd0);
      chk("nofwd_fwd_b", obs_fb, 2'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         if (rst) set_rst(1'b0);
         else if ($urandom_range(0, 49) == 0) set_rst(1'b1);
         drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
